// File: rtl/alu_pkg.sv
// Shared widths and FSM state encoding for the alu and the sequencer that drives it.
package alu_pkg;

  localparam int ALU_W = 8;
  localparam int RES_W = 16;
  localparam int SEL_W = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } seq_state_t;

endpackage

// File: rtl/alu_sequencer.sv
// Drives registered operands into a combinational alu, waits a fixed settle time,
// then returns the captured result on a valid/ready response port (single op or sweep).
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int NUM_OPS       = 8
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             req_valid_in,
  output logic             req_ready_out,
  input  logic [ALU_W-1:0] req_d0_in,
  input  logic [ALU_W-1:0] req_d1_in,
  input  logic [SEL_W-1:0] req_sel_in,
  input  logic             req_sweep_in,
  output logic [ALU_W-1:0] alu_d0_out,
  output logic [ALU_W-1:0] alu_d1_out,
  output logic [SEL_W-1:0] alu_sel_out,
  input  logic [RES_W-1:0] alu_res_in,
  input  logic             alu_gt_in,
  input  logic             alu_eq_in,
  output logic             rsp_valid_out,
  input  logic             rsp_ready_in,
  output logic [RES_W-1:0] rsp_res_out,
  output logic             rsp_gt_out,
  output logic             rsp_eq_out,
  output logic [SEL_W-1:0] rsp_sel_out,
  output logic             rsp_last_out,
  output logic             busy_out
);

  localparam int               CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_OPS - 1);

  seq_state_t       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sweep_q;
  logic [ALU_W-1:0] alu_d0_q;
  logic [ALU_W-1:0] alu_d1_q;
  logic [SEL_W-1:0] alu_sel_q;
  logic             rsp_valid_q;
  logic [RES_W-1:0] rsp_res_q;
  logic             rsp_gt_q;
  logic             rsp_eq_q;
  logic [SEL_W-1:0] rsp_sel_q;
  logic             rsp_last_q;

  // NOTE: every register is cleared by the async reset and updated with <= only, so
  // all state moves together on the edge and no read-before-write ordering exists.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sweep_q     <= 1'b0;
      alu_d0_q    <= '0;
      alu_d1_q    <= '0;
      alu_sel_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_res_q   <= '0;
      rsp_gt_q    <= 1'b0;
      rsp_eq_q    <= 1'b0;
      rsp_sel_q   <= '0;
      rsp_last_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid_in) begin
            alu_d0_q  <= req_d0_in;
            alu_d1_q  <= req_d1_in;
            alu_sel_q <= req_sweep_in ? '0 : req_sel_in;
            sweep_q   <= req_sweep_in;
            cnt_q     <= CNT_INIT;
            state_q   <= SETTLE;
          end
        end
        SETTLE: begin
          // alu outputs are only trusted on the edge where the settle count expires
          if (cnt_q == '0) begin
            rsp_res_q   <= alu_res_in;
            rsp_gt_q    <= alu_gt_in;
            rsp_eq_q    <= alu_eq_in;
            rsp_sel_q   <= alu_sel_q;
            rsp_last_q  <= !sweep_q || (alu_sel_q == LAST_SEL);
            rsp_valid_q <= 1'b1;
            state_q     <= HOLD;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        HOLD: begin
          if (rsp_ready_in) begin
            rsp_valid_q <= 1'b0;
            if (sweep_q && (alu_sel_q != LAST_SEL)) begin
              alu_sel_q <= alu_sel_q + SEL_W'(1);
              cnt_q     <= CNT_INIT;
              state_q   <= SETTLE;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready_out = (state_q == IDLE);
  assign busy_out      = (state_q != IDLE);
  assign alu_d0_out    = alu_d0_q;
  assign alu_d1_out    = alu_d1_q;
  assign alu_sel_out   = alu_sel_q;
  assign rsp_valid_out = rsp_valid_q;
  assign rsp_res_out   = rsp_res_q;
  assign rsp_gt_out    = rsp_gt_q;
  assign rsp_eq_out    = rsp_eq_q;
  assign rsp_sel_out   = rsp_sel_q;
  assign rsp_last_out  = rsp_last_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a behavioural alu wired beside it.
module tb_alu_sequencer;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_d0;
  logic [7:0]  req_d1;
  logic [2:0]  req_sel;
  logic        req_sweep;
  logic [7:0]  alu_d0;
  logic [7:0]  alu_d1;
  logic [2:0]  alu_sel;
  logic [15:0] alu_res;
  logic        alu_gt;
  logic        alu_eq;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_res;
  logic        rsp_gt;
  logic        rsp_eq;
  logic [2:0]  rsp_sel;
  logic        rsp_last;
  logic        busy;

  typedef struct {
    logic [15:0] res;
    logic        gt;
    logic        eq;
    logic [2:0]  sel;
    logic        last;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Hand-computed alu results for d0=12, d1=45, selects 0..7
  logic [15:0] sweep_res [8] = '{16'd57, 16'hFFDF, 16'd540, 16'd12,
                                 16'd45, 16'd33, 16'd3117, 16'd243};

  alu_sequencer #(.SETTLE_CYCLES(2), .NUM_OPS(8)) dut (
    .clk_in        (clk),
    .rst_n_in      (rst_n),
    .req_valid_in  (req_valid),
    .req_ready_out (req_ready),
    .req_d0_in     (req_d0),
    .req_d1_in     (req_d1),
    .req_sel_in    (req_sel),
    .req_sweep_in  (req_sweep),
    .alu_d0_out    (alu_d0),
    .alu_d1_out    (alu_d1),
    .alu_sel_out   (alu_sel),
    .alu_res_in    (alu_res),
    .alu_gt_in     (alu_gt),
    .alu_eq_in     (alu_eq),
    .rsp_valid_out (rsp_valid),
    .rsp_ready_in  (rsp_ready),
    .rsp_res_out   (rsp_res),
    .rsp_gt_out    (rsp_gt),
    .rsp_eq_out    (rsp_eq),
    .rsp_sel_out   (rsp_sel),
    .rsp_last_out  (rsp_last),
    .busy_out      (busy)
  );

  // Behavioural alu beside the sequencer
  always_comb begin
    alu_res = '0;
    case (alu_sel)
      3'd0: alu_res = {8'h0, alu_d0} + {8'h0, alu_d1};
      3'd1: alu_res = {8'h0, alu_d0} - {8'h0, alu_d1};
      3'd2: alu_res = {8'h0, alu_d0} * {8'h0, alu_d1};
      3'd3: alu_res = {8'h0, alu_d0 & alu_d1};
      3'd4: alu_res = {8'h0, alu_d0 | alu_d1};
      3'd5: alu_res = {8'h0, alu_d0 ^ alu_d1};
      3'd6: alu_res = {alu_d0, alu_d1};
      default: alu_res = {8'h0, ~alu_d0};
    endcase
  end
  assign alu_gt = alu_d0 > alu_d1;
  assign alu_eq = alu_d0 == alu_d1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic void push(input logic [15:0] res, input logic gt, input logic eq,
                               input logic [2:0] sel, input logic last);
    exp_t e;
    e.res = res; e.gt = gt; e.eq = eq; e.sel = sel; e.last = last;
    sb.push_back(e);
  endfunction

  // Monitor: a handshake happens on the next rising edge when valid & ready are seen here
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp", 32'(rsp_sel), 32'hFFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_res",  32'(rsp_res),  32'(e.res));
        check("rsp_gt",   32'(rsp_gt),   32'(e.gt));
        check("rsp_eq",   32'(rsp_eq),   32'(e.eq));
        check("rsp_sel",  32'(rsp_sel),  32'(e.sel));
        check("rsp_last", 32'(rsp_last), 32'(e.last));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || sb.size() != 0) && n < 200) begin tick(); n++; end
    check(name, 32'(busy || sb.size() != 0), 32'd0);
  endtask

  // Handshake one request in IDLE; returns just after edge T
  task automatic issue(input logic [7:0] d0, input logic [7:0] d1,
                       input logic [2:0] sel, input logic sweep);
    req_valid = 1'b1; req_d0 = d0; req_d1 = d1; req_sel = sel; req_sweep = sweep;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_busy"},      32'(busy),      32'd0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_alu_ops"},   32'({alu_d0, alu_d1, alu_sel}), 32'd0);
    check({tag, "_rsp_data"},  32'({rsp_res, rsp_gt, rsp_eq, rsp_sel, rsp_last}), 32'd0);
  endtask

  initial begin
    int n;
    logic [21:0] snap;
    rst_n = 1'b0; req_valid = 1'b0; req_d0 = '0; req_d1 = '0;
    req_sel = '0; req_sweep = 1'b0; rsp_ready = 1'b1;
    #12;
    check_reset_outputs("reset");
    @(negedge clk); rst_n = 1'b1;
    tick();

    // Single op: ready drops at T, response at T+2, IDLE at T+3
    push(16'd12, 1'b0, 1'b0, 3'd3, 1'b1);
    issue(8'd12, 8'd45, 3'd3, 1'b0);
    check("single_ready_low", 32'(req_ready), 32'd0);
    check("single_busy", 32'(busy), 32'd1);
    check("single_alu_ops", 32'({alu_d0, alu_d1, alu_sel}), 32'({8'd12, 8'd45, 3'd3}));
    tick();
    check("single_valid_t1", 32'(rsp_valid), 32'd0);
    tick();
    check("single_valid_t2", 32'(rsp_valid), 32'd1);
    tick();
    check("single_idle_t3", 32'({busy, req_ready, rsp_valid}), 32'b010);

    // Sweep with backpressure on sel 2 and a new request held high throughout
    for (int i = 0; i < 8; i++) push(sweep_res[i], 1'b0, 1'b0, 3'(i), i == 7);
    push(16'd144, 1'b1, 1'b0, 3'd0, 1'b1);
    issue(8'd12, 8'd45, 3'd5, 1'b1);
    check("sweep_first_sel", 32'(alu_sel), 32'd0);
    req_valid = 1'b1; req_d0 = 8'd99; req_d1 = 8'd45; req_sel = 3'd0; req_sweep = 1'b0;
    n = 0;
    while (alu_sel != 3'd2 && n < 100) begin tick(); n++; end
    check("bp_reach_sel2", 32'(alu_sel), 32'd2);
    rsp_ready = 1'b0;
    n = 0;
    while (!rsp_valid && n < 100) begin tick(); n++; end
    check("bp_valid", 32'(rsp_valid), 32'd1);
    snap = {rsp_res, rsp_gt, rsp_eq, rsp_sel, rsp_last};
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_rsp_stable", 32'({rsp_res, rsp_gt, rsp_eq, rsp_sel, rsp_last}), 32'(snap));
      check("bp_state", 32'({rsp_valid, alu_sel, req_ready, alu_d0}), 32'({1'b1, 3'd2, 1'b0, 8'd12}));
    end
    rsp_ready = 1'b1;
    n = 0;
    while (!req_ready && n < 200) begin
      check("sweep_req_ignored", 32'(alu_d0), 32'd12);
      tick(); n++;
    end
    check("sweep_done", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    check("held_req_taken", 32'({alu_d0, alu_sel, busy}), 32'({8'd99, 3'd0, 1'b1}));
    wait_idle("held_req_idle");

    // Equality and greater-than
    push(16'd400, 1'b0, 1'b1, 3'd0, 1'b1);
    issue(8'd200, 8'd200, 3'd0, 1'b0);
    wait_idle("eq_idle");
    push(16'd1, 1'b1, 1'b0, 3'd1, 1'b1);
    issue(8'd201, 8'd200, 3'd1, 1'b0);
    wait_idle("gt_idle");

    // Reset mid-sweep while sel 4 is being presented
    for (int i = 0; i < 4; i++) push(sweep_res[i], 1'b0, 1'b0, 3'(i), 1'b0);
    issue(8'd12, 8'd45, 3'd0, 1'b1);
    n = 0;
    while (!(rsp_valid && rsp_sel == 3'd4) && n < 100) begin tick(); n++; end
    check("rst_reach_sel4", 32'({rsp_valid, rsp_sel}), 32'({1'b1, 3'd4}));
    #1 rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    check("midrst_sb_drained", 32'(sb.size()), 32'd0);
    tick(); tick();
    @(negedge clk); rst_n = 1'b1;
    tick();
    push(16'd33, 1'b0, 1'b0, 3'd5, 1'b1);
    issue(8'd12, 8'd45, 3'd5, 1'b0);
    wait_idle("post_rst_idle");

    check("sb_empty_end", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
